// File: rtl/param_fixed_divider.sv
// Sequential restoring fixed-point divider: q = trunc(a * 2^FRAC / b), one quotient bit per clock.
// Optional two's-complement operands, divide-by-zero detection and early overflow abort.
module param_fixed_divider #(
    parameter int WIDTH  = 10,
    parameter int FRAC   = 5,
    parameter int SIGNED = 0
) (
    input  logic             clk,
    input  logic             sclr_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             valid,
    output logic             dvz,
    output logic             ovf
);

    localparam int N  = WIDTH + FRAC;
    localparam int CW = $clog2(N + 1);
    localparam logic [WIDTH-1:0] POS_LIM = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] NEG_LIM = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_CHECK, S_ITER, S_FIX, S_DONE, S_DVZ, S_OVF
    } state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] a_reg, b_reg;
    logic [WIDTH-1:0] bmag;
    logic [N-1:0]     dividend;
    logic [WIDTH:0]   acc;
    logic [N-1:0]     quo;
    logic [CW-1:0]    cnt;
    logic             neg;
    logic             early_ovf;

    logic [WIDTH-1:0] a_mag, b_mag;
    logic             sign_x;
    logic [WIDTH:0]   acc_shift, acc_sub;
    logic             qbit;
    logic [WIDTH-1:0] fix_mag, fix_res, limit;
    logic             fix_ovf;

    always_comb begin
        a_mag  = a_reg;
        b_mag  = b_reg;
        sign_x = 1'b0;
        if (SIGNED != 0) begin
            if (a_reg[WIDTH-1]) a_mag = ~a_reg + 1'b1;
            if (b_reg[WIDTH-1]) b_mag = ~b_reg + 1'b1;
            sign_x = a_reg[WIDTH-1] ^ b_reg[WIDTH-1];
        end
    end

    // The extra accumulator bit keeps the trial compare from wrapping.
    always_comb begin
        acc_shift = (acc << 1) | (WIDTH+1)'(dividend[N-1]);
        qbit      = acc_shift >= {1'b0, bmag};
        acc_sub   = acc_shift - {1'b0, bmag};
    end

    // A negative result may reach one step further than a positive one.
    always_comb begin
        fix_mag = quo[WIDTH-1:0];
        limit   = neg ? NEG_LIM : POS_LIM;
        fix_ovf = ((quo >> WIDTH) != '0) || ((SIGNED != 0) && (fix_mag > limit));
        fix_res = neg ? (~fix_mag + 1'b1) : fix_mag;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start) state_next = S_LOAD;
            S_LOAD:  state_next = S_CHECK;
            S_CHECK: state_next = (bmag == '0) ? S_DVZ : S_ITER;
            S_ITER: begin
                if (early_ovf)             state_next = S_OVF;
                else if (cnt == CW'(1))    state_next = S_FIX;
            end
            S_FIX:   state_next = fix_ovf ? S_OVF : S_DONE;
            S_DONE,
            S_DVZ,
            S_OVF:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge sclr_n) begin
        if (!sclr_n) begin
            state     <= S_IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            bmag      <= '0;
            dividend  <= '0;
            acc       <= '0;
            quo       <= '0;
            cnt       <= '0;
            neg       <= 1'b0;
            early_ovf <= 1'b0;
            q         <= '0;
        end else begin
            state <= state_next;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_reg <= a;
                        b_reg <= b;
                    end
                end
                S_LOAD: begin
                    dividend  <= N'(a_mag) << FRAC;
                    bmag      <= b_mag;
                    neg       <= sign_x;
                    acc       <= '0;
                    quo       <= '0;
                    cnt       <= CW'(N);
                    early_ovf <= 1'b0;
                end
                S_ITER: begin
                    // A set bit while cnt > WIDTH has weight >= 2^WIDTH and aborts next cycle.
                    if (!early_ovf) begin
                        acc       <= qbit ? acc_sub : acc_shift;
                        dividend  <= dividend << 1;
                        quo       <= {quo[N-2:0], qbit};
                        cnt       <= cnt - 1'b1;
                        early_ovf <= qbit && (cnt > CW'(WIDTH));
                    end
                end
                default: ;
            endcase
            if (state_next == S_DONE)
                q <= fix_res;
            else if ((state_next == S_DVZ) || (state_next == S_OVF))
                q <= '0;
        end
    end

    assign busy  = (state != S_IDLE);
    assign valid = (state == S_DONE);
    assign dvz   = (state == S_DVZ);
    assign ovf   = (state == S_OVF);

endmodule

// File: tb/tb_param_fixed_divider.sv
// Bench for param_fixed_divider: unsigned and signed instances, table vectors,
// hand-written corner sequences and randomized operands against an arithmetic model.
module tb_param_fixed_divider;

    localparam int W = 10;
    localparam int F = 5;
    localparam int N = W + F;
    localparam int K_NONE = 0;
    localparam int K_DONE = 1;
    localparam int K_DVZ  = 2;
    localparam int K_OVF  = 3;

    logic         clk = 1'b0;
    logic         sclr_n = 1'b0;
    logic         start_u = 1'b0;
    logic         start_s = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [W-1:0] q_u, q_s;
    logic         busy_u, valid_u, dvz_u, ovf_u;
    logic         busy_s, valid_s, dvz_s, ovf_s;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    param_fixed_divider #(.WIDTH(W), .FRAC(F), .SIGNED(0)) dut_u (
        .clk(clk), .sclr_n(sclr_n), .start(start_u), .a(a), .b(b),
        .q(q_u), .busy(busy_u), .valid(valid_u), .dvz(dvz_u), .ovf(ovf_u)
    );

    param_fixed_divider #(.WIDTH(W), .FRAC(F), .SIGNED(1)) dut_s (
        .clk(clk), .sclr_n(sclr_n), .start(start_s), .a(a), .b(b),
        .q(q_s), .busy(busy_s), .valid(valid_s), .dvz(dvz_s), .ovf(ovf_s)
    );

    typedef struct {
        bit           sgn;
        logic [W-1:0] a;
        logic [W-1:0] b;
        int           kind;
        logic [W-1:0] q;
        int           lat;
    } vec_t;

    typedef struct {
        int           kind;
        logic [W-1:0] q;
        int           lat;
        bit           viol;
        bit           busy_after;
    } obs_t;

    function automatic void sel(input bit sgn, output logic [W-1:0] qq,
                                output logic bs, output logic v, output logic d, output logic o);
        qq = sgn ? q_s     : q_u;
        bs = sgn ? busy_s  : busy_u;
        v  = sgn ? valid_s : valid_u;
        d  = sgn ? dvz_s   : dvz_u;
        o  = sgn ? ovf_s   : ovf_u;
    endfunction

    // Reference: exact quotient from integer arithmetic, early abort at the first quotient bit of weight >= 2^W.
    function automatic void model(input bit sgn, input logic [W-1:0] av, input logic [W-1:0] bv,
                                  output int kind, output logic [W-1:0] qe, output int lat);
        longint sa, sb, ma, mb, m, val;
        int     msb;
        bit     neg;
        sa = sgn ? longint'($signed(av)) : longint'(av);
        sb = sgn ? longint'($signed(bv)) : longint'(bv);
        qe = '0;
        if (sb == 0) begin
            kind = K_DVZ;
            lat  = 2;
            return;
        end
        neg = (sa < 0) != (sb < 0);
        ma  = (sa < 0) ? -sa : sa;
        mb  = (sb < 0) ? -sb : sb;
        m   = (ma * (64'd1 << F)) / mb;
        if (m >= (64'd1 << W)) begin
            msb = 0;
            for (int i = 0; i < 2 * N; i++)
                if (m[i]) msb = i;
            kind = K_OVF;
            lat  = 4 + (N - 1 - msb);
            return;
        end
        lat = N + 3;
        val = neg ? -m : m;
        if (sgn && (val > (2 ** (W - 1) - 1) || val < -(2 ** (W - 1)))) begin
            kind = K_OVF;
        end else begin
            kind = K_DONE;
            qe   = val[W-1:0];
        end
    endfunction

    task automatic cmp(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Launch one operation and watch it to its end pulse; glitch_at > 0 pulses start mid-operation.
    task automatic apply_stimulus(input bit sgn, input logic [W-1:0] av, input logic [W-1:0] bv,
                                  input int glitch_at, output obs_t r);
        logic [W-1:0] qq;
        logic bs, v, d, o;
        r.kind = K_NONE;
        r.q = '0;
        r.lat = -1;
        r.viol = 1'b0;
        r.busy_after = 1'b1;
        a = av;
        b = bv;
        if (sgn) start_s = 1'b1; else start_u = 1'b1;
        @(posedge clk); #1;
        start_u = 1'b0;
        start_s = 1'b0;
        sel(sgn, qq, bs, v, d, o);
        if (!bs) r.viol = 1'b1;
        for (int k = 1; k <= N + 10; k++) begin
            @(posedge clk); #1;
            if (k == glitch_at + 1) begin
                start_u = 1'b0;
                start_s = 1'b0;
            end
            sel(sgn, qq, bs, v, d, o);
            if ((int'(v) + int'(d) + int'(o)) > 1 || ((v | d | o) && !bs)) r.viol = 1'b1;
            if (v | d | o) begin
                r.kind = v ? K_DONE : (d ? K_DVZ : K_OVF);
                r.q    = qq;
                r.lat  = k;
                @(posedge clk); #1;
                sel(sgn, qq, bs, v, d, o);
                r.busy_after = bs;
                break;
            end
            if (!bs) begin
                r.viol = 1'b1;
                break;
            end
            if (k == glitch_at) begin
                a = W'($urandom);
                b = W'($urandom);
                if (sgn) start_s = 1'b1; else start_u = 1'b1;
            end
        end
    endtask

    task automatic check_output(input string name, input obs_t r, input int kind,
                                input logic [W-1:0] qe, input int lat);
        cmp({name, ".kind"}, r.kind, kind);
        cmp({name, ".q"}, int'(r.q), int'(qe));
        cmp({name, ".latency"}, r.lat, lat);
        cmp({name, ".flags"}, int'(r.viol), 0);
        cmp({name, ".busy_fall"}, int'(r.busy_after), 0);
    endtask

    initial begin
        vec_t         tbl[19];
        obs_t         r;
        int           ek, el;
        logic [W-1:0] eq, av, bv;
        bit           sgn;

        tbl[0]  = '{1'b0, 10'd6,    10'd4,    K_DONE, 10'd48,   18};
        tbl[1]  = '{1'b0, 10'd7,    10'd0,    K_DVZ,  10'd0,    2};
        tbl[2]  = '{1'b0, 10'd1000, 10'd1,    K_OVF,  10'd0,    4};
        tbl[3]  = '{1'b1, 10'h3FA,  10'd4,    K_DONE, 10'h3D0,  18};
        tbl[4]  = '{1'b1, 10'h200,  10'd32,   K_DONE, 10'h200,  18};
        tbl[5]  = '{1'b1, 10'd511,  10'd16,   K_OVF,  10'd0,    18};
        tbl[6]  = '{1'b0, 10'd1023, 10'd1023, K_DONE, 10'd32,   18};
        tbl[7]  = '{1'b0, 10'd0,    10'd5,    K_DONE, 10'd0,    18};
        tbl[8]  = '{1'b0, 10'd31,   10'd1,    K_DONE, 10'd992,  18};
        tbl[9]  = '{1'b0, 10'd32,   10'd1,    K_OVF,  10'd0,    8};
        tbl[10] = '{1'b0, 10'd1023, 10'd31,   K_OVF,  10'd0,    8};
        tbl[11] = '{1'b1, 10'h3FF,  10'h3FF,  K_DONE, 10'd32,   18};
        tbl[12] = '{1'b1, 10'h3F0,  10'd1,    K_DONE, 10'h200,  18};
        tbl[13] = '{1'b1, 10'd16,   10'd1,    K_OVF,  10'd0,    18};
        tbl[14] = '{1'b1, 10'h201,  10'h200,  K_DONE, 10'd31,   18};
        tbl[15] = '{1'b1, 10'd7,    10'h3FE,  K_DONE, 10'h390,  18};
        tbl[16] = '{1'b1, 10'h3FA,  10'd0,    K_DVZ,  10'd0,    2};
        tbl[17] = '{1'b0, 10'd1023, 10'd1,    K_OVF,  10'd0,    4};
        tbl[18] = '{1'b1, 10'h200,  10'd1,    K_OVF,  10'd0,    4};

        repeat (3) @(posedge clk);
        #1;
        cmp("reset.q_u", int'(q_u), 0);
        cmp("reset.q_s", int'(q_s), 0);
        cmp("reset.busy", int'(busy_u) + int'(busy_s), 0);
        cmp("reset.pulses", int'(valid_u) + int'(dvz_u) + int'(ovf_u)
                          + int'(valid_s) + int'(dvz_s) + int'(ovf_s), 0);
        @(negedge clk);
        sclr_n = 1'b1;

        for (int i = 0; i < 19; i++) begin
            apply_stimulus(tbl[i].sgn, tbl[i].a, tbl[i].b, 0, r);
            check_output($sformatf("tbl%0d", i), r, tbl[i].kind, tbl[i].q, tbl[i].lat);
        end

        apply_stimulus(1'b0, 10'd6, 10'd4, 5, r);
        check_output("start_glitch", r, K_DONE, 10'd48, 18);

        a = 10'd6;
        b = 10'd4;
        start_u = 1'b1;
        @(posedge clk); #1;
        start_u = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        sclr_n = 1'b0;
        #1;
        cmp("abort.busy", int'(busy_u), 0);
        cmp("abort.q", int'(q_u), 0);
        repeat (2) begin
            @(posedge clk); #1;
            cmp("abort.pulses", int'(valid_u) + int'(dvz_u) + int'(ovf_u) + int'(busy_u), 0);
        end
        @(negedge clk);
        sclr_n = 1'b1;
        apply_stimulus(1'b0, 10'd3, 10'd3, 0, r);
        check_output("after_abort", r, K_DONE, 10'd32, 18);

        for (int i = 0; i < 1500; i++) begin
            sgn = (i % 2) == 1;
            av  = W'($urandom);
            bv  = W'($urandom);
            case ($urandom_range(0, 3))
                0: ;
                1: av = W'($urandom_range(0, 63));
                2: bv = W'($urandom_range(0, 3));
                default: bv = av ^ W'($urandom_range(0, 7));
            endcase
            model(sgn, av, bv, ek, eq, el);
            apply_stimulus(sgn, av, bv, 0, r);
            check_output($sformatf("rnd%0d", i), r, ek, eq, el);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
